// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reservation-station dispatch logic.
package tomasulo_pkg;
   localparam int ENTRIES = 4;
   localparam int POS_W   = 2;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ISSUED = 2'd2
   } entry_state_t;

   typedef enum logic {
      U_IDLE = 1'b0,
      U_BUSY = 1'b1
   } unit_state_t;

   localparam logic CLS_SUMSUB = 1'b0;
   localparam logic CLS_LDSD   = 1'b1;

   function automatic logic [POS_W-1:0] onehotToPos(input logic [ENTRIES-1:0] oneHot);
      logic [POS_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (oneHot[i]) pos = pos | POS_W'(i);
      end
      return pos;
   endfunction
endpackage

// File: rtl/oldest_ready_picker.sv
// Grants the oldest candidate: i_age[a][b] set means position a is older than b.
module oldest_ready_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0][N-1:0] i_age,
   input  logic [N-1:0]        i_cand,
   output logic [N-1:0]        o_grant,
   output logic                o_valid
);

   // A candidate wins when no other candidate is older; the diagonal is always clear.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         o_grant[i] = i_cand[i];
         for (int j = 0; j < N; j++) begin
            if (i_cand[j] && i_age[j][i]) o_grant[i] = 1'b0;
         end
      end
   end

   assign o_valid = |i_cand;

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Tracks reservation-station entries and dispatches the oldest ready entry to each ULA.
module rs_dispatch_scheduler
   import tomasulo_pkg::entry_state_t, tomasulo_pkg::unit_state_t,
          tomasulo_pkg::ST_FREE, tomasulo_pkg::ST_WAIT, tomasulo_pkg::ST_ISSUED,
          tomasulo_pkg::U_IDLE, tomasulo_pkg::U_BUSY,
          tomasulo_pkg::CLS_SUMSUB, tomasulo_pkg::CLS_LDSD,
          tomasulo_pkg::onehotToPos;
#(
   parameter int ENTRIES = tomasulo_pkg::ENTRIES,
   parameter int POS_W   = tomasulo_pkg::POS_W
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           alloc_valid,
   input  logic [POS_W-1:0]               alloc_pos,
   input  logic                           alloc_ldsd,
   input  logic [ENTRIES-1:0]             entry_ready,
   input  logic                           sumsub_done,
   input  logic                           ldsd_done,
   output logic                           issue_sumsub,
   output logic [POS_W-1:0]               issue_sumsub_pos,
   output logic                           issue_ldsd,
   output logic [POS_W-1:0]               issue_ldsd_pos,
   output logic [ENTRIES-1:0]             free_mask,
   output logic [$clog2(ENTRIES+1)-1:0]   occupancy,
   output logic                           rs_full,
   output logic                           sched_err
);

   localparam int OCC_W = $clog2(ENTRIES + 1);

   entry_state_t                 r_state [ENTRIES];
   logic [ENTRIES-1:0]           r_cls;
   logic [ENTRIES-1:0][ENTRIES-1:0] r_age;
   unit_state_t                  r_ssState, r_ldState;
   logic [POS_W-1:0]             r_ssPos, r_ldPos;
   logic                         r_issueSs, r_issueLd;
   logic [POS_W-1:0]             r_issueSsPos, r_issueLdPos;
   logic [ENTRIES-1:0]           r_freeMask;
   logic [OCC_W-1:0]             r_occ;
   logic                         r_full, r_err;

   logic [ENTRIES-1:0]           w_ssCand, w_ldCand, w_ssGrant, w_ldGrant;
   logic                         w_ssValid, w_ldValid;
   logic                         w_ssDispatch, w_ldDispatch, w_ssDone, w_ldDone, w_allocOk;
   logic [POS_W-1:0]             w_ssGrantPos, w_ldGrantPos;
   entry_state_t                 w_nextState [ENTRIES];
   logic [ENTRIES-1:0]           w_freeMask;
   logic [OCC_W-1:0]             w_nextOcc;

   // Ready bits only count for waiting entries of the unit's own class.
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         w_ssCand[i] = (r_state[i] == ST_WAIT) && (r_cls[i] == CLS_SUMSUB) && entry_ready[i];
         w_ldCand[i] = (r_state[i] == ST_WAIT) && (r_cls[i] == CLS_LDSD) && entry_ready[i];
      end
   end

   oldest_ready_picker #(.N(ENTRIES)) u_ssPicker (
      .i_age(r_age), .i_cand(w_ssCand), .o_grant(w_ssGrant), .o_valid(w_ssValid)
   );

   oldest_ready_picker #(.N(ENTRIES)) u_ldPicker (
      .i_age(r_age), .i_cand(w_ldCand), .o_grant(w_ldGrant), .o_valid(w_ldValid)
   );

   assign w_ssGrantPos = onehotToPos(w_ssGrant);
   assign w_ldGrantPos = onehotToPos(w_ldGrant);
   assign w_ssDispatch = (r_ssState == U_IDLE) && w_ssValid;
   assign w_ldDispatch = (r_ldState == U_IDLE) && w_ldValid;
   assign w_ssDone     = sumsub_done && (r_ssState == U_BUSY);
   assign w_ldDone     = ldsd_done && (r_ldState == U_BUSY);
   assign w_allocOk    = alloc_valid && (r_state[alloc_pos] == ST_FREE);

   // Dispatch, release and allocation always touch distinct positions in one cycle.
   always_comb begin
      w_nextState = r_state;
      w_freeMask  = '0;
      if (w_ssDispatch) w_nextState[w_ssGrantPos] = ST_ISSUED;
      if (w_ldDispatch) w_nextState[w_ldGrantPos] = ST_ISSUED;
      if (w_ssDone) begin
         w_nextState[r_ssPos] = ST_FREE;
         w_freeMask[r_ssPos]  = 1'b1;
      end
      if (w_ldDone) begin
         w_nextState[r_ldPos] = ST_FREE;
         w_freeMask[r_ldPos]  = 1'b1;
      end
      if (w_allocOk) w_nextState[alloc_pos] = ST_WAIT;
      w_nextOcc = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (w_nextState[i] != ST_FREE) w_nextOcc = w_nextOcc + OCC_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) r_state[i] <= ST_FREE;
         r_cls        <= '0;
         r_age        <= '0;
         r_ssState    <= U_IDLE;
         r_ldState    <= U_IDLE;
         r_ssPos      <= '0;
         r_ldPos      <= '0;
         r_issueSs    <= 1'b0;
         r_issueLd    <= 1'b0;
         r_issueSsPos <= '0;
         r_issueLdPos <= '0;
         r_freeMask   <= '0;
         r_occ        <= '0;
         r_full       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_nextState;
         // New entry is younger than every occupied one; its own row starts clear.
         if (w_allocOk) begin
            r_cls[alloc_pos] <= alloc_ldsd;
            for (int j = 0; j < ENTRIES; j++) begin
               r_age[alloc_pos][j] <= 1'b0;
               r_age[j][alloc_pos] <= (r_state[j] != ST_FREE);
            end
         end
         if (w_ssDispatch) begin
            r_ssState <= U_BUSY;
            r_ssPos   <= w_ssGrantPos;
         end else if (w_ssDone) begin
            r_ssState <= U_IDLE;
         end
         if (w_ldDispatch) begin
            r_ldState <= U_BUSY;
            r_ldPos   <= w_ldGrantPos;
         end else if (w_ldDone) begin
            r_ldState <= U_IDLE;
         end
         r_issueSs    <= w_ssDispatch;
         r_issueLd    <= w_ldDispatch;
         r_issueSsPos <= w_ssDispatch ? w_ssGrantPos : '0;
         r_issueLdPos <= w_ldDispatch ? w_ldGrantPos : '0;
         r_freeMask   <= w_freeMask;
         r_occ        <= w_nextOcc;
         r_full       <= (w_nextOcc == OCC_W'(ENTRIES));
         r_err        <= r_err | (alloc_valid && !w_allocOk)
                               | (sumsub_done && (r_ssState == U_IDLE))
                               | (ldsd_done && (r_ldState == U_IDLE));
      end
   end

   assign issue_sumsub     = r_issueSs;
   assign issue_sumsub_pos = r_issueSsPos;
   assign issue_ldsd       = r_issueLd;
   assign issue_ldsd_pos   = r_issueLdPos;
   assign free_mask        = r_freeMask;
   assign occupancy        = r_occ;
   assign rs_full          = r_full;
   assign sched_err        = r_err;

endmodule
